// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way arbiter and its request buffer stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package arb_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  // True when exactly one bit of the grant vector is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Index of the set bit of a one-hot vector; zero for a zero vector.
  function automatic port_idx_t onehot_idx(input logic [3:0] v);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (v[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head-of-queue visible on pop_data.
// Latency: push visible in count/empty one cycle later; pop_data is the current head.
// Backpressure: full refuses a push even in a cycle that also pops; pop on empty is ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_buffer.sv
// Per-port input queues feeding a round-robin arbiter; grant pops into one output register.
// Latency: push->req 1 cycle, gnt->out_valid/out_data 1 cycle, 1 transaction/cycle sustained.
// Backpressure: in_ready = queue not full; a grant is ignored while the output slot is occupied and not draining.
module arb_req_buffer
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          gnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output port_idx_t                     out_port,
  output logic                          grant_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0] full_vec;
  logic [NUM_PORTS-1:0] empty_vec;
  logic [NUM_PORTS-1:0] pop_vec;
  logic [DATA_W-1:0]    head [NUM_PORTS];
  logic [CW-1:0]        cnt  [NUM_PORTS];

  logic      slot_free;
  logic      illegal;
  logic      load;
  port_idx_t gidx;

  // Producers are held off during reset so nothing is accepted into a queue being cleared.
  assign in_ready  = rst ? '0 : ~full_vec;
  assign slot_free = !out_valid || out_ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i] && in_ready[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop_vec[i]),
      .pop_data  (head[i]),
      .full      (full_vec[i]),
      .empty     (empty_vec[i]),
      .count     (cnt[i])
    );

    assign req[i] = (cnt[i] != '0);
  end

  // Grant decode: a multi-hot grant or a grant to an empty queue is a protocol error;
  // a legal grant against a blocked output slot is simply dropped and re-issued later.
  always_comb begin
    gidx    = onehot_idx(gnt);
    illegal = (gnt != '0) && (!is_onehot(gnt) || ((gnt & empty_vec) != '0));
    load    = (gnt != '0) && !illegal && slot_free;
    pop_vec = load ? gnt : '0;
  end

  // Output register: load replaces the held entry, otherwise a handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head[gidx];
      out_port  <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          grant_err <= 1'b0;
    else if (illegal) grant_err <= 1'b1;
  end

endmodule

// File: tb/tb_arb_req_buffer.sv
module tb_arb_req_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        grant_err;

  always #5 clk = ~clk;

  arb_req_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_port  (out_port),
    .grant_err (grant_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-port queues plus the state of the output slot.
  logic [7:0] mq [4][$];
  logic [9:0] sb [$];          // expected {port, data} in output order
  bit         m_ov;
  logic [7:0] m_dat;
  logic [1:0] m_port;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random legal grant chosen from the model's non-empty queues.
  function automatic logic [3:0] pick();
    int cand [$];
    for (int i = 0; i < 4; i++) if (mq[i].size() != 0) cand.push_back(i);
    if (cand.size() == 0) return 4'b0000;
    return 4'b0001 << cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  // One clock: drive inputs, advance the model by the rules, then compare after the edge.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g, input logic r);
    logic [3:0] acc;
    logic [3:0] exp_req;
    logic [3:0] exp_rdy;
    bit         loaded;
    int         k;
    logic [7:0] x;
    in_valid  = v;
    in_data   = d;
    gnt       = g;
    out_ready = r;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      sb.delete();
      m_ov = 0; m_err = 0; m_dat = '0; m_port = '0;
    end else begin
      for (int i = 0; i < 4; i++) acc[i] = v[i] && (mq[i].size() < 4);
      loaded = 0;
      if (g != 4'b0000) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        if ($countones(g) != 1 || mq[k].size() == 0) begin
          m_err = 1;
        end else if (!m_ov || r) begin
          x = mq[k].pop_front();
          sb.push_back({k[1:0], x});
          m_ov = 1; m_dat = x; m_port = k[1:0];
          loaded = 1;
        end
      end
      if (!loaded && r) m_ov = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(d[i*8 +: 8]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_req[i] = (mq[i].size() != 0);
      exp_rdy[i] = !rst && (mq[i].size() < 4);
    end
    chk("req", {28'b0, req}, {28'b0, exp_req});
    chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    chk("grant_err", {31'b0, grant_err}, {31'b0, m_err});
    if (m_ov || rst) begin
      chk("held_data", {24'b0, out_data}, {24'b0, m_dat});
      chk("held_port", {30'b0, out_port}, {30'b0, m_port});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'b0, 32'b0, 4'b0, 1'b0);
    step(4'b0, 32'b0, 4'b0, 1'b0);
    rst = 1'b0;
    step(4'b0, 32'b0, 4'b0, 1'b0);
  endtask

  // Monitor: every consumed output must match the next scoreboard entry.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got port %0d data %0h, expected nothing", out_port, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", {24'b0, out_data}, {24'b0, e[7:0]});
          chk("out_port", {30'b0, out_port}, {30'b0, e[9:8]});
        end
      end
    end
  end

  initial begin
    int left;
    rst = 1'b1; in_valid = '0; in_data = '0; gnt = '0; out_ready = 1'b0;
    m_ov = 0; m_err = 0; m_dat = '0; m_port = '0;

    // Reset / idle
    do_reset();

    // Single port: 0xA1 then 0xA2 on port 2
    step(4'b0100, 32'h00A1_0000, 4'b0000, 1'b1);
    step(4'b0100, 32'h00A2_0000, 4'b0100, 1'b1);
    step(4'b0000, 32'h0,         4'b0100, 1'b1);
    step(4'b0000, 32'h0,         4'b0000, 1'b1);

    // Fill port 0 with five pushes, then drain the four accepted
    for (int i = 1; i <= 5; i++) step(4'b0001, i, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++)  step(4'b0000, 32'h0, 4'b0001, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);

    // Output stall on port 1
    step(4'b0010, 32'h0000_1100, 4'b0000, 1'b1);
    step(4'b0010, 32'h0000_1200, 4'b0000, 1'b1);
    step(4'b0000, 32'h0,         4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 4'b0010, 1'b0);
    step(4'b0000, 32'h0, 4'b0010, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);

    // All four ports with rotating grants
    step(4'b1111, 32'h4030_2010, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b0001, 1'b1);
    step(4'b0000, 32'h0, 4'b0010, 1'b1);
    step(4'b0000, 32'h0, 4'b0100, 1'b1);
    step(4'b0000, 32'h0, 4'b1000, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);

    // Illegal grants: multi-hot, then grant to empty port 3
    step(4'b0011, 32'h0000_BBAA, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b0011, 1'b1);
    step(4'b0000, 32'h0, 4'b1000, 1'b1);
    step(4'b0000, 32'h0, 4'b0001, 1'b1);
    step(4'b0000, 32'h0, 4'b0010, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    do_reset();

    // Randomized traffic, mostly legal grants with occasional arbitrary ones
    for (int n = 0; n < 600; n++) begin
      logic [3:0] g;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 85)      g = pick();
      else if (sel < 95) g = 4'b0000;
      else               g = 4'($urandom_range(0, 15));
      step(4'($urandom_range(0, 15)), $urandom, g, ($urandom_range(0, 3) != 0));
      if (n == 300) do_reset();
    end

    // Drain everything still queued, bounded
    left = 0;
    for (int n = 0; n < 200; n++) begin
      left = int'(m_ov);
      for (int i = 0; i < 4; i++) left += mq[i].size();
      if (left == 0) break;
      step(4'b0000, 32'h0, pick(), 1'b1);
    end
    chk("drain_left", left, 0);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
